// File: rtl/gray_pkg.sv
// Shared types for the gray-scale streaming pipeline.
//   PIX_W : gray pixel width
//   CNT_W : width of row/column counters (supports images up to 2048x2048)
//   pix_t : one gray pixel
//   win_t : 3x3 neighbourhood, indexed [row][col], row 0 = top, col 0 = left
package gray_pkg;
    localparam int PIX_W = 8;
    localparam int CNT_W = 11;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [0:2][0:2] win_t;
endpackage

// File: rtl/gray_line_buffer.sv
// Single-port line buffer with read-before-write semantics.
// The read port is combinational so the old contents at addr are visible in
// the same cycle that new data is written there.
//   clk   : rising-edge clock
//   we    : write enable
//   addr  : column address
//   wdata : data written at the end of the cycle
//   rdata : current contents at addr (value before this cycle's write)
module gray_line_buffer #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end
endmodule

// File: rtl/gray_window_3x3.sv
// Streaming 3x3 window generator for raster-order gray pixels.
// Buffers two image lines and presents a registered 3x3 window centred on
// each interior pixel; border pixels never become centres.
//   clk             : rising-edge clock
//   rst             : synchronous active-high reset
//   pix_valid       : pix_in carries a valid pixel
//   pix_in          : gray pixel, raster order
//   win_valid       : window outputs valid this cycle
//   win_00..win_22  : window pixels, win_rc = row r (0 top), col c (0 left)
//   win_row/win_col : coordinates of the centre pixel win_11
//   done            : last window of the frame emitted; sticky until rst
module gray_window_3x3
    import gray_pkg::*;
#(
    parameter int ROW = 1153,
    parameter int COL = 2048
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    output logic             win_valid,
    output logic [PIX_W-1:0] win_00,
    output logic [PIX_W-1:0] win_01,
    output logic [PIX_W-1:0] win_02,
    output logic [PIX_W-1:0] win_10,
    output logic [PIX_W-1:0] win_11,
    output logic [PIX_W-1:0] win_12,
    output logic [PIX_W-1:0] win_20,
    output logic [PIX_W-1:0] win_21,
    output logic [PIX_W-1:0] win_22,
    output logic [CNT_W-1:0] win_row,
    output logic [CNT_W-1:0] win_col,
    output logic             done
);
    localparam int AW = (COL > 1) ? $clog2(COL) : 1;

    logic [CNT_W-1:0] in_col;
    logic [CNT_W-1:0] in_row;
    logic             accept;
    logic             last_col;
    logic             last_pix;
    logic             interior;
    pix_t             tap1;
    pix_t             tap2;
    win_t             win;

    // Once done is set the frame is closed; extra pixels are dropped.
    assign accept   = pix_valid && !done && !rst;
    assign last_col = (in_col == CNT_W'(COL - 1));
    assign last_pix = last_col && (in_row == CNT_W'(ROW - 1));
    // Gating on in_col >= 2 keeps all three window columns on the current line.
    assign interior = (in_row >= CNT_W'(2)) && (in_col >= CNT_W'(2));

    // Both lines share one buffer: low half is the previous line, high half
    // the line before it. Each write ages the previous-line pixel upward.
    gray_line_buffer #(
        .DEPTH (COL),
        .WIDTH (2 * PIX_W),
        .AW    (AW)
    ) u_lb (
        .clk   (clk),
        .we    (accept),
        .addr  (in_col[AW-1:0]),
        .wdata ({tap1, pix_in}),
        .rdata ({tap2, tap1})
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            in_col    <= '0;
            in_row    <= '0;
            win       <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            done      <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= tap2;
                win[1][2] <= tap1;
                win[2][2] <= pix_in;

                if (last_col) begin
                    in_col <= '0;
                    in_row <= in_row + CNT_W'(1);
                end else begin
                    in_col <= in_col + CNT_W'(1);
                end

                if (interior) begin
                    win_valid <= 1'b1;
                    win_row   <= in_row - CNT_W'(1);
                    win_col   <= in_col - CNT_W'(1);
                end

                if (last_pix) begin
                    done <= 1'b1;
                end
            end
        end
    end

    assign win_00 = win[0][0];
    assign win_01 = win[0][1];
    assign win_02 = win[0][2];
    assign win_10 = win[1][0];
    assign win_11 = win[1][1];
    assign win_12 = win[1][2];
    assign win_20 = win[2][0];
    assign win_21 = win[2][1];
    assign win_22 = win[2][2];
endmodule

// File: tb/tb_gray_window_3x3.sv
module tb_gray_window_3x3;
    localparam int R = 4;
    localparam int C = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [7:0]  pix_in;
    logic        win_valid;
    logic [7:0]  win_00, win_01, win_02, win_10, win_11, win_12, win_20, win_21, win_22;
    logic [10:0] win_row, win_col;
    logic        done;

    gray_window_3x3 #(.ROW(R), .COL(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .win_valid (win_valid),
        .win_00    (win_00),
        .win_01    (win_01),
        .win_02    (win_02),
        .win_10    (win_10),
        .win_11    (win_11),
        .win_12    (win_12),
        .win_20    (win_20),
        .win_21    (win_21),
        .win_22    (win_22),
        .win_row   (win_row),
        .win_col   (win_col),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state: the image as written so far and raster position.
    logic [7:0]  img [R][C];
    int          mr, mc;
    bit          mdone;
    logic [71:0] last_win;
    logic [21:0] last_cent;
    logic [71:0] wq[$];
    logic [21:0] cq[$];
    logic [71:0] ref_q[$];

    function automatic logic [71:0] pack9(input int a, b, c, d, e, f, g, h, i);
        return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
    endfunction

    function automatic logic [71:0] dut_win();
        return {win_00, win_01, win_02, win_10, win_11, win_12, win_20, win_21, win_22};
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel, then 'gap' idle cycles, checking every cycle.
    task automatic send(input logic [7:0] v, input int gap);
        bit          ev;
        bit          was_done;
        logic [71:0] ew;
        logic [21:0] ecent;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_in    = v;
        @(posedge clk);
        #1;
        ev       = 1'b0;
        was_done = mdone;
        ew       = '0;
        ecent    = '0;
        if (!mdone) begin
            img[mr][mc] = v;
            if (mr >= 2 && mc >= 2) begin
                ev    = 1'b1;
                ew    = pack9(img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                              img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                              img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]);
                ecent = {11'(mr - 1), 11'(mc - 1)};
            end
            if (mr == R - 1 && mc == C - 1) mdone = 1'b1;
            mc++;
            if (mc == C) begin
                mc = 0;
                mr++;
            end
        end
        chk("win_valid", 72'(win_valid), 72'(ev));
        if (ev) begin
            chk("window", dut_win(), ew);
            chk("centre", 72'({win_row, win_col}), 72'(ecent));
            wq.push_back(dut_win());
            cq.push_back({win_row, win_col});
            last_win  = ew;
            last_cent = ecent;
        end else if (was_done) begin
            chk("hold_window", dut_win(), last_win);
            chk("hold_centre", 72'({win_row, win_col}), 72'(last_cent));
        end
        chk("done", 72'(done), 72'(mdone));
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            pix_valid = 1'b0;
            pix_in    = 8'($urandom);
            @(posedge clk);
            #1;
            chk("gap_win_valid", 72'(win_valid), 72'(0));
            chk("gap_done", 72'(done), 72'(mdone));
        end
    endtask

    task automatic do_reset(input bit check_zero, input bit junk_valid);
        @(negedge clk);
        rst       = 1'b1;
        pix_valid = junk_valid;
        pix_in    = 8'hAA;
        @(posedge clk);
        #1;
        if (check_zero) begin
            chk("rst_win_valid", 72'(win_valid), 72'(0));
            chk("rst_done", 72'(done), 72'(0));
            chk("rst_window", dut_win(), 72'(0));
            chk("rst_centre", 72'({win_row, win_col}), 72'(0));
        end
        @(negedge clk);
        rst       = 1'b0;
        pix_valid = 1'b0;
        mr = 0;
        mc = 0;
        mdone = 1'b0;
        last_win  = '0;
        last_cent = '0;
        wq.delete();
        cq.delete();
    endtask

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_in    = 8'h00;
        do_reset(1'b1, 1'b0);

        // Frame of index values, continuous.
        for (int i = 0; i < R * C; i++) send(8'(i), 0);
        chk("t1_count", 72'(wq.size()), 72'(6));
        if (wq.size() == 6) begin
            chk("t1_first", wq[0], pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
            chk("t1_first_c", 72'(cq[0]), 72'({11'd1, 11'd1}));
            chk("t3_pre_wrap_c", 72'(cq[2]), 72'({11'd1, 11'd3}));
            chk("t3_post_wrap", wq[3], pack9(5, 6, 7, 10, 11, 12, 15, 16, 17));
            chk("t3_post_wrap_c", 72'(cq[3]), 72'({11'd2, 11'd1}));
            chk("t1_last", wq[5], pack9(7, 8, 9, 12, 13, 14, 17, 18, 19));
            chk("t1_last_c", 72'(cq[5]), 72'({11'd2, 11'd3}));
        end
        ref_q = wq;

        // Extra pixels after done are ignored; then reset clears everything.
        for (int i = 0; i < 10; i++) send(8'($urandom), 0);
        do_reset(1'b1, 1'b0);

        // Same frame, pix_valid toggling.
        for (int i = 0; i < R * C; i++) send(8'(i), 1);
        chk("t2_count", 72'(wq.size()), 72'(ref_q.size()));
        if (wq.size() == ref_q.size())
            for (int k = 0; k < wq.size(); k++) chk("t2_seq", wq[k], ref_q[k]);
        do_reset(1'b1, 1'b0);

        // Reset mid-frame (with a junk pixel presented during rst), fresh frame +100.
        for (int i = 0; i < 10; i++) send(8'(i), 0);
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < R * C; i++) send(8'(i + 100), 0);
        chk("t4_count", 72'(wq.size()), 72'(6));
        if (wq.size() > 0)
            chk("t4_first", wq[0], pack9(100, 101, 102, 105, 106, 107, 110, 111, 112));

        // Reset after windows have already been emitted, then random frame.
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) send(8'($urandom), 0);
        do_reset(1'b1, 1'b0);

        // Random frames with random gaps.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < R * C; i++)
                send(8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            chk("rand_count", 72'(wq.size()), 72'((R - 2) * (C - 2)));
            for (int i = 0; i < 3; i++) send(8'($urandom), 0);
            do_reset(1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/gray_window_3x3.md
Name: gray_window_3x3

Overview:
Streaming 3x3 neighbourhood generator placed directly downstream of the RGB-to-gray converter.
- Consumes one 8-bit gray pixel per valid cycle in raster order and buffers two full image lines.
- Presents a registered 3x3 window, centred on an interior pixel, to the following convolution/edge stage.
- Signals frame completion when the last window of the frame has been emitted.

Parameters:
ROW, 1153, image height in lines
COL, 2048, image width in pixels (line-buffer depth)
PIX_W, 8, gray pixel width in bits

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; one clock, synchronous, active-high
pix_valid  input  1  pix_in carries a valid pixel this cycle
pix_in  input  PIX_W  gray pixel, raster order, row 0 col 0 first
win_valid  output  1  window outputs valid this cycle
win_00..win_22  output  PIX_W each (9 ports)  window, win_rc = row r (0=top), col c (0=left); win_11 is the centre
win_row  output  11  row index of centre pixel
win_col  output  11  column index of centre pixel
done  output  1  frame complete; sticky until rst

Behaviour:
- Reset (sync, active-high): all outputs 0; col/row counters 0; shift registers 0. Line-buffer RAM contents are not cleared and must be don't-care for correctness.
- Input counters:
  - in_col increments on each pix_valid; wraps at COL-1 to 0 and increments in_row.
  - When in_row reaches ROW-1 and in_col reaches COL-1, that pixel is the final one.
  - Any further pix_valid is ignored until rst (no buffer/counter change).
- Line buffers:
  - Two COL-deep buffers, lb0 = previous line and lb1 = line before that, addressed by in_col.
  - Read-before-write on each pix_valid: tap1 = lb0[in_col], tap2 = lb1[in_col]; then lb1[in_col] <= tap1 and lb0[in_col] <= pix_in.
- Window shift:
  - Three 3-deep column shift registers (top = tap2, mid = tap1, bottom = pix_in) shift left on pix_valid only.
  - pix_valid low: everything holds; win_valid deasserts.
- Output validity:
  - win_valid is registered and asserts the cycle after a pix_valid with in_row >= 2 and in_col >= 2.
  - Only interior centres are emitted: win_row = in_row-1, win_col = in_col-1.
  - No border padding; a frame produces (ROW-2)*(COL-2) windows.
  - Windows never straddle a line wrap, because the in_col >= 2 gating guarantees all three columns come from the current line.
- Latency: 1 cycle from the bottom-right pixel accepted to the window presented.
- done: asserts 1 cycle after the final pixel is accepted (coincident with the last win_valid) and stays high until rst.
- Reset mid-frame: counters return to 0 and win_valid drops the next cycle. Stale line-buffer data is not emitted because rows 0-1 are refilled before any win_valid.
- Gaps: pix_valid may drop for any number of cycles mid-line or between lines with no effect on output values.
- Widths: counters are 11 bits (COL, ROW <= 2048). No arithmetic on pixel data.

Decomposition:
- Shared package gray_pkg holds:
  - localparam PIX_W = 8 and CNT_W = 11;
  - typedef pix_t (logic [PIX_W-1:0]);
  - typedef win_t (3x3 array of pix_t), for use by downstream filter stages.
- One sub-module, gray_line_buffer: single-port COL x PIX_W RAM with read-before-write, instantiated twice (or once at 2*PIX_W width).

Test Plan:
1. ROW=4, COL=5, pixel value = index (0..19), pix_valid continuous:
   - first win_valid is 1 cycle after index 12;
   - win = {0,1,2 / 5,6,7 / 10,11,12}, centre (1,1);
   - exactly 6 windows total;
   - last window is {7,8,9 / 12,13,14 / 17,18,19}, centre (2,3);
   - done rises with it.
2. Same frame with pix_valid toggling 1/0 every cycle → identical window sequence; win_valid never high in a cycle following pix_valid=0.
3. Line boundary: the window after index 14 has centre (1,3). Index 15 (col 0) and index 16 (col 1) produce no win_valid. The next window, centre (2,1), is {5,6,7 / 10,11,12 / 15,16,17}.
4. Reset mid-frame after index 9, then a fresh frame with values +100 → first window {100,101,102 / 105,106,107 / 110,111,112}; no window contains pre-reset data; done low until the new frame ends.
5. After done, drive 10 extra pix_valid pixels → no win_valid, done stays 1, counters unchanged. Then rst → done=0 and all outputs 0 the cycle after.
6. Default parameters (1153 x 2048) with random pixels vs reference model → 1151*2046 windows, all matching; done asserts exactly once.
